data_addr_gen: RTL

DATA_ADDR_GEN -- requirements
Module: data_addr_gen

---
 rtl/winocnn_pkg.sv | 21 ++
 rtl/data_addr_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/winocnn_pkg.sv
// winocnn_pkg -- definitions shared by the Winograd CNN datapath blocks.
//   state_e   : data_addr_gen sweep FSM states
//   ADDR_W    : data-memory row address width
//   TILE_W    : width of the tile index / tile counter
//   TILE_ROWS : rows per Winograd F(2x2,3x3) input tile
//   TILE_STEP : row step between consecutive tiles
package winocnn_pkg;

   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned TILE_W    = 7;
   localparam int unsigned TILE_ROWS = 4;
   localparam int unsigned TILE_STEP = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE_A = 2'd1,
      ISSUE_B = 2'd2,
      DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/data_addr_gen.sv
// data_addr_gen -- row-address generator for Winograd F(2x2,3x3) input tiles.
// A sweep over a feature map of num_rows rows issues, per tile t
// (r = base_addr + 2t), pair A (r, r+1) then pair B (r+2, r+3) on the two
// data-memory read ports. All outputs are registered: start sampled in
// cycle 0 gives the first pair in cycle 2 and done in the cycle after the
// last pair.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : one-cycle sweep request (ignored while busy)
//   base_addr, num_rows  : first row address / map height, sampled with start
//   stall                : backpressure, freezes issue
//   addr_1_out/addr_2_out: read addresses for port 1 / port 2 (mod 256)
//   package_1/2_valid_out: address qualifiers
//   tile_idx, tile_last  : tile of the current pair / final pair of sweep
//   busy, done, cfg_err  : status; cfg_err is sticky until next legal start
//
// Build option DATA_ADDR_GEN_STATS_EN adds issue_cnt[15:0], a saturating
// count of valid pairs issued since reset.
module data_addr_gen
   import winocnn_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_rows,
   input  logic              stall,
   output logic [ADDR_W-1:0] addr_1_out,
   output logic [ADDR_W-1:0] addr_2_out,
   output logic              package_1_valid_out,
   output logic              package_2_valid_out,
   output logic [TILE_W-1:0] tile_idx,
   output logic              tile_last,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
`ifdef DATA_ADDR_GEN_STATS_EN
   ,
   output logic [15:0]       issue_cnt
`endif
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   row_q, row_d;
   logic [TILE_W-1:0]   tile_q, tile_d;
   logic [TILE_W-1:0]   last_tile_q, last_tile_d;
   logic [ADDR_W-1:0]   addr_1_q, addr_1_d;
   logic [ADDR_W-1:0]   addr_2_q, addr_2_d;
   logic                valid_q, valid_d;
   logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
   logic                tile_last_q, tile_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                cfg_err_q, cfg_err_d;
   logic [ADDR_W-1:0]   span;
   logic                cfg_bad;

   // Index of the last tile is (H-2)/2 - 1 = (H-4)/2.
   assign span    = num_rows - ADDR_W'(TILE_ROWS);
   assign cfg_bad = (num_rows < ADDR_W'(TILE_ROWS)) || num_rows[0];

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      tile_d      = tile_q;
      last_tile_d = last_tile_q;
      addr_1_d    = addr_1_q;
      addr_2_d    = addr_2_q;
      tile_idx_d  = tile_idx_q;
      cfg_err_d   = cfg_err_q;
      valid_d     = 1'b0;
      tile_last_d = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_bad) begin
                  // Illegal geometry: flag it and finish without going busy.
                  cfg_err_d = 1'b1;
                  done_d    = 1'b1;
               end else begin
                  cfg_err_d   = 1'b0;
                  row_d       = base_addr;
                  tile_d      = '0;
                  last_tile_d = span[ADDR_W-1:1];
                  state_d     = ISSUE_A;
               end
            end
         end
         ISSUE_A: begin
            if (!stall) begin
               addr_1_d   = row_q;
               addr_2_d   = row_q + ADDR_W'(1);
               valid_d    = 1'b1;
               tile_idx_d = tile_q;
               state_d    = ISSUE_B;
            end
         end
         ISSUE_B: begin
            if (!stall) begin
               addr_1_d   = row_q + ADDR_W'(TILE_STEP);
               addr_2_d   = row_q + ADDR_W'(TILE_STEP + 1);
               valid_d    = 1'b1;
               tile_idx_d = tile_q;
               if (tile_q == last_tile_q) begin
                  tile_last_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  tile_d  = tile_q + TILE_W'(1);
                  row_d   = row_q + ADDR_W'(TILE_STEP);
                  state_d = ISSUE_A;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         row_q       <= '0;
         tile_q      <= '0;
         last_tile_q <= '0;
         addr_1_q    <= '0;
         addr_2_q    <= '0;
         valid_q     <= 1'b0;
         tile_idx_q  <= '0;
         tile_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         tile_q      <= tile_d;
         last_tile_q <= last_tile_d;
         addr_1_q    <= addr_1_d;
         addr_2_q    <= addr_2_d;
         valid_q     <= valid_d;
         tile_idx_q  <= tile_idx_d;
         tile_last_q <= tile_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign addr_1_out          = addr_1_q;
   assign addr_2_out          = addr_2_q;
   assign package_1_valid_out = valid_q;
   assign package_2_valid_out = valid_q;
   assign tile_idx            = tile_idx_q;
   assign tile_last           = tile_last_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign cfg_err             = cfg_err_q;

`ifdef DATA_ADDR_GEN_STATS_EN
   logic [15:0] issue_cnt_q, issue_cnt_d;

   always_comb begin
      issue_cnt_d = issue_cnt_q;
      if (valid_d && (issue_cnt_q != '1))
         issue_cnt_d = issue_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) issue_cnt_q <= '0;
      else       issue_cnt_q <= issue_cnt_d;
   end

   assign issue_cnt = issue_cnt_q;
`endif

endmodule
